// File: rtl/cnn_layer_accel_quad_job_ctrl.sv
// Purpose: loads the pixel-sequence program into sequence memory, then runs row-by-row ingest jobs.
// Latency: job_accept, pix_wr_* and seq_rd_data are registered (1 cycle); request/ready/complete follow state.
// Backpressure: config and pixels accepted one per cycle; pixel_ready drops once a row fetch is full.
module cnn_layer_accel_quad_job_ctrl #(
    parameter int C_BRAM_DEPTH  = 512,
    parameter int C_PIXEL_WIDTH = 16
) (
    input  logic                       clk_if,
    input  logic                       rst,
    input  logic [3:0]                 config_valid,
    output logic [3:0]                 config_accept,
    input  logic [8*C_PIXEL_WIDTH-1:0] config_data,
    input  logic [9:0]                 num_input_rows_cfg,
    input  logic [9:0]                 num_input_cols_cfg,
    input  logic [9:0]                 pfb_full_count_cfg,
    input  logic [9:0]                 kernel_offset_cfg,
    input  logic                       last_kernel,
    input  logic                       job_start,
    output logic                       job_accept,
    output logic                       job_fetch_request,
    input  logic                       job_fetch_ack,
    input  logic                       job_fetch_complete,
    output logic                       job_complete,
    input  logic                       job_complete_ack,
    output logic [9:0]                 job_kernel_offset,
    output logic                       job_last_kernel,
    input  logic                       pixel_valid,
    output logic                       pixel_ready,
    input  logic [8*C_PIXEL_WIDTH-1:0] pixel_data,
    output logic                       pix_wr_en,
    output logic [9:0]                 pix_wr_row,
    output logic [9:0]                 pix_wr_col,
    output logic [8*C_PIXEL_WIDTH-1:0] pix_wr_data,
    input  logic [11:0]                seq_rd_addr,
    output logic [C_PIXEL_WIDTH-1:0]   seq_rd_data
);

    localparam int ADDR_W = $clog2(C_BRAM_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_STREAM,
        S_WAIT_FC,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    // Sequence words are opaque here (address/parity/group/row-map/reserved fields are consumed downstream).
    logic [7:0][C_PIXEL_WIDTH-1:0] seq_mem [C_BRAM_DEPTH];
    logic [7:0][C_PIXEL_WIDTH-1:0] rd_beat;

    logic [ADDR_W-1:0] beat_cnt;
    logic              seq_loaded;
    logic              cfg_hs;
    logic              pix_hs;
    logic              job_accept_nxt;

    logic [9:0] row_cnt;
    logic [9:0] col_cnt;
    logic [9:0] rows_q;
    logic [9:0] cols_q;
    logic [9:0] pfb_q;

    // Upper config lanes and the column count are carried for the quad's other lanes and datapaths.
    logic unused_ok;
    assign unused_ok = ^{config_valid[3:1], cols_q};

    assign config_accept = {3'b000, config_valid[0] & ~seq_loaded & (state == S_IDLE)};
    assign cfg_hs        = config_accept[0];
    assign pix_hs        = pixel_valid & pixel_ready;

    // State register.
    always_ff @(posedge clk_if) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs; an empty row fetch skips straight to waiting for completion.
    always_comb begin
        state_nxt         = state;
        job_accept_nxt    = 1'b0;
        job_fetch_request = 1'b0;
        pixel_ready       = 1'b0;
        job_complete      = 1'b0;
        case (state)
            S_IDLE: begin
                if (job_start && seq_loaded) begin
                    job_accept_nxt = 1'b1;
                    state_nxt      = S_REQ;
                end
            end
            S_REQ: begin
                job_fetch_request = 1'b1;
                if (job_fetch_ack) begin
                    state_nxt = (pfb_q == 10'd0) ? S_WAIT_FC : S_STREAM;
                end
            end
            S_STREAM: begin
                pixel_ready = (col_cnt < pfb_q);
                if (!(col_cnt < pfb_q)) begin
                    state_nxt = S_WAIT_FC;
                end else if (pixel_valid && (col_cnt == pfb_q - 10'd1)) begin
                    state_nxt = S_WAIT_FC;
                end
            end
            S_WAIT_FC: begin
                if (job_fetch_complete) begin
                    state_nxt = (row_cnt == rows_q) ? S_DONE : S_REQ;
                end
            end
            S_DONE: begin
                job_complete = 1'b1;
                if (job_complete_ack) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Config beat counter; the program is loaded once per reset.
    always_ff @(posedge clk_if) begin
        if (rst) begin
            beat_cnt   <= '0;
            seq_loaded <= 1'b0;
        end else if (cfg_hs) begin
            beat_cnt <= beat_cnt + 1'b1;
            if (beat_cnt == ADDR_W'(C_BRAM_DEPTH - 1)) begin
                seq_loaded <= 1'b1;
            end
        end
    end

    // Sequence memory write: one 8-word beat per accepted config handshake, contents survive reset.
    always_ff @(posedge clk_if) begin
        if (cfg_hs && !rst) begin
            seq_mem[beat_cnt] <= config_data;
        end
    end

    assign rd_beat = seq_mem[seq_rd_addr[ADDR_W+2:3]];

    // Registered sequence-word read port.
    always_ff @(posedge clk_if) begin
        if (rst) begin
            seq_rd_data <= '0;
        end else begin
            seq_rd_data <= rd_beat[seq_rd_addr[2:0]];
        end
    end

    // Job configuration capture and row/column progress counters.
    always_ff @(posedge clk_if) begin
        if (rst) begin
            job_accept        <= 1'b0;
            rows_q            <= '0;
            cols_q            <= '0;
            pfb_q             <= '0;
            job_kernel_offset <= '0;
            job_last_kernel   <= 1'b0;
            row_cnt           <= '0;
            col_cnt           <= '0;
        end else begin
            job_accept <= job_accept_nxt;
            if (job_accept_nxt) begin
                rows_q            <= num_input_rows_cfg;
                cols_q            <= num_input_cols_cfg;
                pfb_q             <= pfb_full_count_cfg;
                job_kernel_offset <= kernel_offset_cfg;
                job_last_kernel   <= last_kernel;
                row_cnt           <= '0;
            end
            if (state == S_REQ && job_fetch_ack) begin
                col_cnt <= '0;
            end else if (pix_hs) begin
                col_cnt <= col_cnt + 10'd1;
            end
            if (state == S_WAIT_FC && job_fetch_complete) begin
                row_cnt <= row_cnt + 10'd1;
            end
        end
    end

    // Registered row-buffer write port.
    always_ff @(posedge clk_if) begin
        if (rst) begin
            pix_wr_en   <= 1'b0;
            pix_wr_row  <= '0;
            pix_wr_col  <= '0;
            pix_wr_data <= '0;
        end else begin
            pix_wr_en <= pix_hs;
            if (pix_hs) begin
                pix_wr_row  <= row_cnt;
                pix_wr_col  <= col_cnt;
                pix_wr_data <= pixel_data;
            end
        end
    end

endmodule

// File: tb/tb_cnn_layer_accel_quad_job_ctrl.sv
`timescale 1ns/1ps
module tb_cnn_layer_accel_quad_job_ctrl;

    logic         clk_if = 1'b0;
    logic         rst;
    logic [3:0]   config_valid;
    logic [3:0]   config_accept;
    logic [127:0] config_data;
    logic [9:0]   num_input_rows_cfg, num_input_cols_cfg, pfb_full_count_cfg, kernel_offset_cfg;
    logic         last_kernel;
    logic         job_start, job_accept, job_fetch_request, job_fetch_ack, job_fetch_complete;
    logic         job_complete, job_complete_ack;
    logic [9:0]   job_kernel_offset;
    logic         job_last_kernel;
    logic         pixel_valid, pixel_ready;
    logic [127:0] pixel_data;
    logic         pix_wr_en;
    logic [9:0]   pix_wr_row, pix_wr_col;
    logic [127:0] pix_wr_data;
    logic [11:0]  seq_rd_addr;
    logic [15:0]  seq_rd_data;

    int vectors = 0;
    int errors  = 0;

    // Reference image of the sequence memory, indexed by word address.
    logic [15:0] seq_model [4096];

    always #5 clk_if = ~clk_if;

    cnn_layer_accel_quad_job_ctrl dut (
        .clk_if(clk_if), .rst(rst),
        .config_valid(config_valid), .config_accept(config_accept), .config_data(config_data),
        .num_input_rows_cfg(num_input_rows_cfg), .num_input_cols_cfg(num_input_cols_cfg),
        .pfb_full_count_cfg(pfb_full_count_cfg), .kernel_offset_cfg(kernel_offset_cfg),
        .last_kernel(last_kernel),
        .job_start(job_start), .job_accept(job_accept), .job_fetch_request(job_fetch_request),
        .job_fetch_ack(job_fetch_ack), .job_fetch_complete(job_fetch_complete),
        .job_complete(job_complete), .job_complete_ack(job_complete_ack),
        .job_kernel_offset(job_kernel_offset), .job_last_kernel(job_last_kernel),
        .pixel_valid(pixel_valid), .pixel_ready(pixel_ready), .pixel_data(pixel_data),
        .pix_wr_en(pix_wr_en), .pix_wr_row(pix_wr_row), .pix_wr_col(pix_wr_col),
        .pix_wr_data(pix_wr_data),
        .seq_rd_addr(seq_rd_addr), .seq_rd_data(seq_rd_data)
    );

    task automatic step();
        @(posedge clk_if);
        @(negedge clk_if);
    endtask

    function automatic logic [187:0] all_outputs();
        return {config_accept, job_accept, job_fetch_request, job_complete, job_kernel_offset,
                job_last_kernel, pixel_ready, pix_wr_en, pix_wr_row, pix_wr_col, pix_wr_data,
                seq_rd_data};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        vectors++;
        if (all_outputs() !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h required 0", all_outputs());
        end
    endtask

    task automatic test_config_load();
        int accepts = 0;
        int cyc = 0;
        logic [127:0] d;
        rst = 1'b0;
        while (accepts < 512 && cyc < 1000) begin
            config_valid = {3'($urandom), 1'b1};
            for (int w = 0; w < 8; w++) d[16*w +: 16] = 16'($urandom);
            config_data = d;
            job_start   = (cyc == 100);
            #1;
            if (cyc == 0) begin
                vectors++;
                if (config_accept !== 4'b0001) begin
                    errors++;
                    $display("FAIL first_cfg_accept: got %b required 0001", config_accept);
                end
            end
            vectors++;
            if (job_accept !== 1'b0 || config_accept[3:1] !== 3'b000) begin
                errors++;
                $display("FAIL load_side_outputs: job_accept %b accept %b required 0/000",
                         job_accept, config_accept);
            end
            if (config_accept[0] === 1'b1) begin
                for (int w = 0; w < 8; w++) seq_model[accepts*8 + w] = d[16*w +: 16];
                accepts++;
            end
            step();
            cyc++;
        end
        job_start = 1'b0;
        #1;
        vectors++;
        if (accepts != 512 || config_accept !== 4'b0000) begin
            errors++;
            $display("FAIL load_count: got %0d accepts accept=%b required 512 accepts accept=0000",
                     accepts, config_accept);
        end
        step();
        vectors++;
        if (job_accept !== 1'b0) begin
            errors++;
            $display("FAIL early_job_start: job_accept got %b required 0", job_accept);
        end
        config_valid = 4'b0000;
    endtask

    task automatic test_seq_read();
        logic [11:0] a;
        for (int i = 0; i < 12; i++) begin
            if (i == 0) a = 12'd8;
            else if (i == 1) a = 12'd0;
            else if (i == 2) a = 12'd4095;
            else a = 12'($urandom);
            seq_rd_addr = a;
            step();
            vectors++;
            if (seq_rd_data !== seq_model[a]) begin
                errors++;
                $display("FAIL seq_read addr %0d: got %h required %h", a, seq_rd_data, seq_model[a]);
            end
        end
    endtask

    // Runs one complete job and checks every handshake and row-buffer write against the rules.
    task automatic run_job(input logic [9:0] rows, input logic [9:0] pfb, input int hold_max);
        logic [9:0]   kern;
        logic         lk;
        logic [127:0] d;
        logic         hs;
        int           c;
        int           budget;
        int           hold;
        kern = 10'($urandom);
        lk   = 1'($urandom);
        num_input_rows_cfg = rows;
        num_input_cols_cfg = 10'($urandom);
        pfb_full_count_cfg = pfb;
        kernel_offset_cfg  = kern;
        last_kernel        = lk;
        job_start = 1'b1;
        step();
        job_start = 1'b0;
        vectors++;
        if (job_accept !== 1'b1 || job_fetch_request !== 1'b1 ||
            job_kernel_offset !== kern || job_last_kernel !== lk) begin
            errors++;
            $display("FAIL job_accept: acc %b req %b koff %h lk %b required 1 1 %h %b",
                     job_accept, job_fetch_request, job_kernel_offset, job_last_kernel, kern, lk);
        end
        num_input_rows_cfg = 10'($urandom);
        pfb_full_count_cfg = 10'($urandom);
        kernel_offset_cfg  = ~kern;
        for (int r = 0; r <= int'(rows); r++) begin
            hold = $urandom_range(0, hold_max);
            for (int h = 0; h <= hold; h++) begin
                vectors++;
                if (job_fetch_request !== 1'b1 || pixel_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL fetch_request row %0d: req %b ready %b required 1 0",
                             r, job_fetch_request, pixel_ready);
                end
                if (h < hold) step();
            end
            job_fetch_ack = 1'b1;
            step();
            job_fetch_ack = 1'b0;
            vectors++;
            if (job_fetch_request !== 1'b0 || (r == 0 && job_accept !== 1'b0)) begin
                errors++;
                $display("FAIL after_ack row %0d: req %b acc %b required 0 0",
                         r, job_fetch_request, job_accept);
            end
            c = 0;
            budget = 0;
            while (c < int'(pfb) && budget < 400) begin
                vectors++;
                if (pixel_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL ready_stream row %0d col %0d: got %b required 1", r, c, pixel_ready);
                end
                pixel_valid = ($urandom_range(0, 3) != 0);
                d = {$urandom, $urandom, $urandom, $urandom};
                pixel_data = d;
                job_fetch_complete = ($urandom_range(0, 7) == 0);
                job_fetch_ack      = ($urandom_range(0, 7) == 0);
                hs = pixel_valid;
                step();
                vectors++;
                if (hs) begin
                    if (pix_wr_en !== 1'b1 || pix_wr_row !== 10'(r) || pix_wr_col !== 10'(c) ||
                        pix_wr_data !== d) begin
                        errors++;
                        $display("FAIL pix_write: en %b row %0d col %0d data %h required 1 %0d %0d %h",
                                 pix_wr_en, pix_wr_row, pix_wr_col, pix_wr_data, r, c, d);
                    end
                    c++;
                end else if (pix_wr_en !== 1'b0) begin
                    errors++;
                    $display("FAIL pix_idle row %0d col %0d: en got %b required 0", r, c, pix_wr_en);
                end
                budget++;
            end
            job_fetch_complete = 1'b0;
            job_fetch_ack      = 1'b0;
            vectors++;
            if (budget >= 400 || pixel_ready !== 1'b0) begin
                errors++;
                $display("FAIL row_end row %0d: ready %b budget %0d required 0 <400", r, pixel_ready, budget);
            end
            pixel_valid = 1'b1;
            hold = $urandom_range(0, 2);
            for (int h = 0; h < hold; h++) begin
                step();
                vectors++;
                if (pix_wr_en !== 1'b0 || job_fetch_request !== 1'b0 || job_complete !== 1'b0) begin
                    errors++;
                    $display("FAIL wait_fc row %0d: en %b req %b done %b required 0 0 0",
                             r, pix_wr_en, job_fetch_request, job_complete);
                end
            end
            job_fetch_complete = 1'b1;
            step();
            job_fetch_complete = 1'b0;
            pixel_valid = 1'b0;
            vectors++;
            if (pix_wr_en !== 1'b0 || job_fetch_request !== (r < int'(rows)) ||
                job_complete !== (r == int'(rows))) begin
                errors++;
                $display("FAIL fetch_complete row %0d: en %b req %b done %b required 0 %b %b",
                         r, pix_wr_en, job_fetch_request, job_complete, r < int'(rows), r == int'(rows));
            end
        end
        hold = $urandom_range(1, 4);
        for (int h = 0; h < hold; h++) begin
            step();
            vectors++;
            if (job_complete !== 1'b1) begin
                errors++;
                $display("FAIL complete_hold: got %b required 1", job_complete);
            end
        end
        job_complete_ack = 1'b1;
        step();
        job_complete_ack = 1'b0;
        vectors++;
        if (job_complete !== 1'b0 || job_fetch_request !== 1'b0) begin
            errors++;
            $display("FAIL complete_ack: done %b req %b required 0 0", job_complete, job_fetch_request);
        end
    endtask

    task automatic test_job_10x10();
        run_job(10'd9, 10'd10, 3);
    endtask

    task automatic test_back_to_back();
        run_job(10'($urandom_range(0, 3)), 10'd0, 2);
        run_job(10'($urandom_range(0, 2)), 10'($urandom_range(1, 5)), 1);
    endtask

    task automatic test_reset_abort();
        num_input_rows_cfg = 10'd3;
        pfb_full_count_cfg = 10'd6;
        job_start = 1'b1;
        step();
        job_start = 1'b0;
        job_fetch_ack = 1'b1;
        step();
        job_fetch_ack = 1'b0;
        pixel_valid = 1'b1;
        pixel_data  = {$urandom, $urandom, $urandom, $urandom};
        repeat (3) step();
        rst = 1'b1;
        step();
        vectors++;
        if (all_outputs() !== '0) begin
            errors++;
            $display("FAIL abort_outputs: got %h required 0", all_outputs());
        end
        rst = 1'b0;
        pixel_valid = 1'b0;
        config_valid = 4'b0001;
        #1;
        vectors++;
        if (config_accept !== 4'b0001) begin
            errors++;
            $display("FAIL abort_cfg_accept: got %b required 0001", config_accept);
        end
        config_valid = 4'b1110;
        #1;
        vectors++;
        if (config_accept !== 4'b0000) begin
            errors++;
            $display("FAIL upper_lanes: got %b required 0000", config_accept);
        end
        config_valid = 4'b0000;
        job_start = 1'b1;
        step();
        job_start = 1'b0;
        vectors++;
        if (job_accept !== 1'b0) begin
            errors++;
            $display("FAIL start_unloaded: job_accept got %b required 0", job_accept);
        end
    endtask

    initial begin
        rst = 1'b1;
        config_valid = '0; config_data = '0;
        num_input_rows_cfg = '0; num_input_cols_cfg = '0; pfb_full_count_cfg = '0;
        kernel_offset_cfg = '0; last_kernel = 1'b0;
        job_start = 1'b0; job_fetch_ack = 1'b0; job_fetch_complete = 1'b0; job_complete_ack = 1'b0;
        pixel_valid = 1'b0; pixel_data = '0; seq_rd_addr = '0;
        @(negedge clk_if);
        test_reset();
        test_config_load();
        test_seq_read();
        test_job_10x10();
        test_back_to_back();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/cnn_layer_accel_quad_job_ctrl.md
# cnn_layer_accel_quad_job_ctrl

Single-clock job and ingest controller of the CNN layer-accelerator quad. It loads the 512-beat pixel-sequence program from the config port into an internal sequence memory, then runs one job. A job fetches an input map row by row over the pixel port and hands each accepted pixel vector to the row buffers through a write port. Cascade, result and core-clock datapaths are outside this block.

## Interface
- C_BRAM_DEPTH, 512: sequence-memory depth in 128-bit beats (eight 16-bit words each).
- C_PIXEL_WIDTH, 16: pixel and sequence-word width.
- clk_if  in  1  sole clock; all logic is rising-edge.
- rst  in  1  synchronous, active-high reset.
- config_valid  in  4  per-lane config valid; only lane 0 is used, bits [3:1] are ignored.
- config_accept  out  4  bit 0 is the lane-0 accept; bits [3:1] are tied 0.
- config_data  in  128  eight sequence words, word w at bits [16w+15:16w].
- num_input_rows_cfg, num_input_cols_cfg  in  10 each  map rows-1 and cols-1.
- pfb_full_count_cfg  in  10  pixels per row fetch.
- kernel_offset_cfg  in  10, last_kernel  in  1: registered at job accept and exposed on job_kernel_offset (out 10) and job_last_kernel (out 1).
- job_start  in  1; job_accept  out  1; job_fetch_request  out  1; job_fetch_ack  in  1; job_fetch_complete  in  1; job_complete  out  1; job_complete_ack  in  1.
- pixel_valid  in  1; pixel_ready  out  1; pixel_data  in  128, eight depth-slice pixels.
- pix_wr_en  out  1; pix_wr_row  out  10; pix_wr_col  out  10; pix_wr_data  out  128: row-buffer write.
- seq_rd_addr  in  12  word address; seq_rd_data  out  16  with 1-cycle read latency.

## Operation
- Sequence word fields:
  - [9:0] sequence address.
  - [10] parity.
  - [11] group start.
  - [12] row-map end.
  - [15:13] reserved, stored unchanged.
- Config load:
  - config_accept[0] = config_valid[0] & !seq_loaded & state==IDLE (combinational).
  - Each handshake writes the 8 words to word addresses 8*beat_cnt+w, then increments beat_cnt.
  - After beat 511 is written, seq_loaded=1. Further config is not accepted until reset.
- FSM states: IDLE, REQ, STREAM, WAIT_FC, DONE.
  - IDLE: when job_start & seq_loaded, pulse job_accept for 1 cycle, latch all cfg inputs, clear row_cnt, go to REQ.
  - REQ: job_fetch_request=1. When job_fetch_ack=1, deassert the request, clear col_cnt, go to STREAM.
  - STREAM: pixel_ready = (col_cnt < pfb_full_count). Each pixel_valid & pixel_ready beat writes (row_cnt, col_cnt, pixel_data) on pix_wr_* and increments col_cnt. When col_cnt reaches pfb_full_count, pixel_ready drops and the FSM goes to WAIT_FC.
  - WAIT_FC: when job_fetch_complete=1, increment row_cnt. If row_cnt was num_input_rows_cfg (the last row), go to DONE; otherwise go to REQ.
  - DONE: job_complete=1 until job_complete_ack=1, then go to IDLE. seq_loaded stays 1, so a new job needs no reload.
- job_fetch_complete seen in STREAM is ignored. job_fetch_ack outside REQ is ignored. job_start outside IDLE, or before seq_loaded, is ignored.
- Counters are 10-bit. pfb_full_count_cfg = 0 means no pixels are expected: pixel_ready stays 0 and the FSM goes directly to WAIT_FC.

## Timing
- Reset values:
  - All outputs 0, config_accept 0.
  - State IDLE; beat_cnt, row_cnt, col_cnt = 0; seq_loaded = 0.
  - Sequence-memory contents are not cleared.
- Reset asserted mid-operation aborts on the next edge and returns to these values.
- Handshake latencies:
  - job_accept is registered: high in the cycle after job_start is sampled in IDLE.
  - job_fetch_request rises in the same cycle job_accept is high.
  - Each REQ→STREAM and WAIT_FC→REQ transition takes 1 cycle.
  - pix_wr_* are registered: valid 1 cycle after the pixel handshake.
- Full throughput: one pixel per cycle while pixel_valid stays high; one config beat per cycle.
- Config is accepted in the very first cycle after reset deasserts.

## Test plan
- Load 512 beats with config_valid[0] held high: exactly 512 accepts, then config_accept[0]=0; seq_rd_addr=8 returns word 0 of beat 1 after 1 cycle.
- job_start before loading completes: job_accept never pulses. job_start after loading: a 1-cycle job_accept, with job_fetch_request=1 in that same cycle.
- 10×10 map (cfg 9/9/10), 10 pixel beats per fetch with random pixel_valid gaps: 100 pix_wr_en pulses, row 0..9 and col 0..9, data matching the stimulus; pixel_ready=0 after the 10th beat of each row.
- After the 10th job_fetch_complete, job_complete holds high until job_complete_ack, then the FSM returns to IDLE and a second job_start is accepted without reloading.
- rst asserted during STREAM: next cycle all outputs are 0 and config_accept[0] follows config_valid[0] again.
- config_valid[3:1]=1 and job_fetch_complete during STREAM: no effect.
